// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC owner, imem handshake, next-PC resolution, halt detection
//
// Ports:
//   clk, rst           clock (rising edge) and synchronous active-high reset
//   imem_req/addr      fetch request and byte address (= pc) to instruction memory
//   imem_ready/rdata   memory response; ready honoured only while fetching
//   inst/pc/inst_valid instruction handed to the core, held until core_ack
//   core_ack           core executed inst; redirect inputs are valid in this cycle
//   branch_taken/br_offset, jump/jump_index, jr/jr_target   redirect resolution
//   halt               sticky, set by the all-zero instruction
//   inst_count         number of acknowledged instructions (wraps)
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    output logic [31:0]      pc,
    output logic             inst_valid,
    input  logic             core_ack,
    input  logic             branch_taken,
    input  logic [31:0]      br_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [31:0]      jr_target,
    output logic             halt,
    output logic [CNT_W-1:0] inst_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t      state;
    logic [31:0] pc_r;
    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] next_pc;

    // The offset is a word offset, so its top two bits fall off after the shift;
    // the low two bits of the JR target are dropped to keep the PC word aligned.
    logic unused_bits;
    assign unused_bits = &{1'b0, br_offset[31:30], jr_target[1:0]};

    assign imem_addr = pc_r;
    assign pc        = pc_r;

    always_comb begin
        pc4       = pc_r + 32'd4;
        br_target = pc4 + {br_offset[29:0], 2'b00};
        next_pc   = pc4;
        if (jr)
            next_pc = {jr_target[31:2], 2'b00};
        else if (jump)
            next_pc = {pc4[31:28], jump_index, 2'b00};
        else if (branch_taken)
            next_pc = br_target;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc_r       <= RESET_PC;
            imem_req   <= 1'b0;
            inst       <= 32'd0;
            inst_valid <= 1'b0;
            halt       <= 1'b0;
            inst_count <= '0;
        end else begin
            case (state)
                // One guaranteed cycle with imem_req low so the memory sees any
                // request abandoned by reset as cancelled.
                S_IDLE: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        imem_req <= 1'b0;
                        if (imem_rdata == 32'd0) begin
                            inst  <= 32'd0;
                            halt  <= 1'b1;
                            state <= S_HALTED;
                        end else begin
                            inst       <= imem_rdata;
                            inst_valid <= 1'b1;
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (core_ack) begin
                        pc_r       <= next_pc;
                        inst_valid <= 1'b0;
                        inst_count <= inst_count + 1'b1;
                        imem_req   <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                    halt       <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking scoreboard bench for inst_fetch
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;
    logic        core_ack = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] br_offset = 32'd0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'd0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic        halt;
    logic [31:0] inst_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb_pc[$];
    logic [31:0] sb_count;
    logic        halt_en = 1'b0;
    logic [31:0] halt_addr = 32'd0;

    inst_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .inst(inst), .pc(pc), .inst_valid(inst_valid),
        .core_ack(core_ack),
        .branch_taken(branch_taken), .br_offset(br_offset),
        .jump(jump), .jump_index(jump_index),
        .jr(jr), .jr_target(jr_target),
        .halt(halt), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_en && a == halt_addr) return 32'd0;
        return a ^ 32'h8000_0013;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic br,
            input logic [31:0] off, input logic jp, input logic [25:0] idx,
            input logic jrr, input logic [31:0] t);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (jrr) return {t[31:2], 2'b00};
        if (jp)  return {p4[31:28], idx, 2'b00};
        if (br)  return p4 + (off << 2);
        return p4;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ready = 1'b0; core_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_pc.delete();
        sb_pc.push_back(32'h0);
        sb_count = 32'd0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++; $display("FAIL idle_req actual=%0b required=0", imem_req);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (imem_req === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL req_timeout actual=0 required=1");
        end
    endtask

    task automatic do_instr(input int waits, input logic br, input logic [31:0] boff,
            input logic jp, input logic [25:0] jidx, input logic jrr, input logic [31:0] jrt);
        bit ok;
        logic [31:0] exp;
        wait_req(ok);
        if (!ok) return;
        exp = sb_pc.pop_front();
        checks++;
        if (imem_addr !== exp) begin
            failures++; $display("FAIL fetch_addr actual=%h required=%h", imem_addr, exp);
        end
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp || inst_valid !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold actual=req%0b/%h/v%0b required=req1/%h/v0",
                         imem_req, imem_addr, inst_valid, exp);
            end
        end
        imem_ready = 1'b1;
        imem_rdata = mem_word(exp);
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        checks++;
        if (inst_valid !== 1'b1 || pc !== exp || inst !== mem_word(exp) || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL issue actual=v%0b pc=%h inst=%h req%0b required=v1 pc=%h inst=%h req0",
                     inst_valid, pc, inst, imem_req, exp, mem_word(exp));
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || pc !== exp || inst !== mem_word(exp)) begin
            failures++; $display("FAIL issue_hold actual=v%0b pc=%h inst=%h", inst_valid, pc, inst);
        end
        branch_taken = br; br_offset = boff; jump = jp; jump_index = jidx;
        jr = jrr; jr_target = jrt; core_ack = 1'b1;
        sb_pc.push_back(model_next(exp, br, boff, jp, jidx, jrr, jrt));
        sb_count++;
        @(negedge clk);
        core_ack = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        br_offset = $urandom; jump_index = 26'($urandom); jr_target = $urandom;
        checks++;
        if (inst_valid !== 1'b0 || inst_count !== sb_count) begin
            failures++;
            $display("FAIL ack actual=v%0b cnt=%0d required=v0 cnt=%0d", inst_valid, inst_count, sb_count);
        end
    endtask

    task automatic check_next_addr();
        bit ok;
        logic [31:0] exp;
        wait_req(ok);
        if (!ok) return;
        exp = sb_pc.pop_front();
        sb_pc.push_front(exp);
        checks++;
        if (imem_addr !== exp) begin
            failures++; $display("FAIL next_addr actual=%h required=%h", imem_addr, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || inst !== 32'd0 || inst_valid !== 1'b0 || halt !== 1'b0 ||
            inst_count !== 32'd0 || pc !== 32'd0 || imem_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_state actual=req%0b inst=%h v%0b h%0b cnt=%0d pc=%h addr=%h required=all zero",
                     imem_req, inst, inst_valid, halt, inst_count, pc, imem_addr);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            failures++; $display("FAIL first_fetch actual=req%0b addr=%h required=req1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 0, 0, 0, 0);
        check_next_addr();
        checks++;
        if (inst_count !== 32'd3) begin
            failures++; $display("FAIL seq_count actual=%0d required=3", inst_count);
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        do_instr(0, 1, 32'd3, 0, 0, 0, 0);   // 0 -> 0x10
        do_instr(4, 0, 0, 0, 0, 0, 0);
        check_next_addr();
    endtask

    task automatic test_redirects();
        do_reset();
        do_instr(0, 1, 32'h0000_003F, 0, 26'h0, 0, 32'h0);           // 0 -> 0x100
        do_instr(0, 1, 32'hFFFF_FFFE, 0, 26'h0, 0, 32'h0);           // -> 0x0FC
        do_instr(1, 0, 32'h0, 0, 26'h0, 1, 32'h4000_0003);           // -> 0x4000_0000
        do_instr(0, 0, 32'h0, 1, 26'h10, 0, 32'h0);                  // -> 0x4000_0040
        do_instr(2, 0, 32'h0, 0, 26'h0, 1, 32'h0000_0207);           // -> 0x204
        do_instr(0, 1, 32'h7, 1, 26'h5, 1, 32'h0000_0300);           // jr wins -> 0x300
        do_instr(0, 0, 32'h0, 1, 26'h3FF_FFFF, 0, 32'h0);            // -> 0x0FFF_FFFC
        do_instr(0, 0, 32'h0, 0, 26'h0, 1, 32'hFFFF_FFFC);           // -> 0xFFFF_FFFC
        do_instr(0, 0, 32'h0, 0, 26'h0, 0, 32'h0);                   // wrap -> 0
        check_next_addr();
        checks++;
        if (inst_count !== 32'd9) begin
            failures++; $display("FAIL redirect_count actual=%0d required=9", inst_count);
        end
    endtask

    task automatic test_halt();
        bit ok;
        logic [31:0] exp;
        do_reset();
        halt_en = 1'b1; halt_addr = 32'h0000_000C;
        for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 0, 0, 0, 0);
        wait_req(ok);
        if (ok) begin
            exp = sb_pc.pop_front();
            imem_ready = 1'b1;
            imem_rdata = mem_word(exp);
            @(negedge clk);
            imem_ready = 1'b0;
            checks++;
            if (halt !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'd0 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL halt_entry actual=h%0b v%0b inst=%h req%0b required=h1 v0 inst=0 req0",
                         halt, inst_valid, inst, imem_req);
            end
            for (int i = 0; i < 6; i++) begin
                core_ack = i[0]; imem_ready = 1'b1; imem_rdata = 32'h1234_5678; jr = 1'b1;
                @(negedge clk);
                checks++;
                if (halt !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 ||
                    inst_count !== 32'd3 || pc !== exp) begin
                    failures++;
                    $display("FAIL halt_sticky actual=h%0b req%0b v%0b cnt=%0d pc=%h required=h1 req0 v0 cnt=3 pc=%h",
                             halt, imem_req, inst_valid, inst_count, pc, exp);
                end
            end
            core_ack = 1'b0; imem_ready = 1'b0; jr = 1'b0;
        end
        halt_en = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        do_reset();
        do_instr(0, 1, 32'd7, 0, 0, 0, 0);   // 0 -> 0x20
        wait_req(ok);
        if (ok) begin
            checks++;
            if (imem_addr !== 32'h20) begin
                failures++; $display("FAIL mid_addr actual=%h required=00000020", imem_addr);
            end
            imem_ready = 1'b1; imem_rdata = mem_word(32'h20); rst = 1'b1;
            @(negedge clk);
            imem_ready = 1'b0; rst = 1'b0;
            checks++;
            if (pc !== 32'd0 || imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_count !== 32'd0) begin
                failures++;
                $display("FAIL mid_reset actual=pc=%h req%0b v%0b cnt=%0d required=pc=0 req0 v0 cnt=0",
                         pc, imem_req, inst_valid, inst_count);
            end
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
                failures++; $display("FAIL mid_refetch actual=req%0b addr=%h required=req1 addr=0", imem_req, imem_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_redirects();
        test_halt();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
